alu_arbiter: RTL and testbench

- Shares the single 32-bit ALU (a, b, ALUControl in; Result1, Result2, ALUFlags out) between NREQ requesters, e.g. the decode/execute path and a multi-cycle multiply/divide sequencer.
- Accepts one operation at a time using round-robin arbitration and holds the operands stable on the ALU for EXEC_CYCLES.
- Captures both results and the flags into a response register, then returns them tagged with the requester index through a valid/ready handshake.

---
 rtl/alu_arbiter.sv | 162 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one 32-bit ALU between NREQ requesters.
// A round-robin grant is made in IDLE; the granted operands are registered
// onto the ALU inputs and held for EXEC_CYCLES cycles, after which the ALU
// results and flags are captured and returned over a valid/ready handshake,
// tagged with the requester index.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_ready        per-requester handshake (ready is one-hot or zero)
//   req_a/req_b/req_ctrl       packed per-requester operands and ALUControl
//   alu_a/alu_b/alu_ctrl       registered operands driven to the ALU
//   alu_result1/2, alu_flags   ALU outputs, captured at the end of EXEC
//   rsp_valid/rsp_ready        response handshake
//   rsp_id, rsp_result1/2,     response payload
//   rsp_flags
module alu_arbiter #(
  parameter int unsigned NREQ        = 2,
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [32*NREQ-1:0]  req_a,
  input  logic [32*NREQ-1:0]  req_b,
  input  logic [3*NREQ-1:0]   req_ctrl,
  output logic [31:0]         alu_a,
  output logic [31:0]         alu_b,
  output logic [2:0]          alu_ctrl,
  input  logic [31:0]         alu_result1,
  input  logic [31:0]         alu_result2,
  input  logic [3:0]          alu_flags,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [2:0]          rsp_id,
  output logic [31:0]         rsp_result1,
  output logic [31:0]         rsp_result2,
  output logic [3:0]          rsp_flags
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state_q, state_d;
  logic [2:0]  last_grant_q, last_grant_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic [2:0]  alu_ctrl_q, alu_ctrl_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [2:0]  rsp_id_q, rsp_id_d;
  logic [31:0] rsp_result1_q, rsp_result1_d;
  logic [31:0] rsp_result2_q, rsp_result2_d;
  logic [3:0]  rsp_flags_q, rsp_flags_d;

  logic        grant_found;
  logic [2:0]  grant_idx;

  // Round-robin scan starting one past the last grant; the first valid
  // requester encountered wins.
  always_comb begin
    int unsigned cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = (32'(last_grant_q) + i) % NREQ;
      if (!grant_found && ((req_valid >> cand) & NREQ'(1)) != '0) begin
        grant_found = 1'b1;
        grant_idx   = 3'(cand);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && grant_found && !reset)
      req_ready = NREQ'(1) << grant_idx;
  end

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    cnt_d         = cnt_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_ctrl_d    = alu_ctrl_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_id_d      = rsp_id_q;
    rsp_result1_d = rsp_result1_q;
    rsp_result2_d = rsp_result2_q;
    rsp_flags_d   = rsp_flags_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          alu_a_d      = 32'(req_a >> (32 * grant_idx));
          alu_b_d      = 32'(req_b >> (32 * grant_idx));
          alu_ctrl_d   = 3'(req_ctrl >> (3 * grant_idx));
          last_grant_d = grant_idx;
          rsp_id_d     = grant_idx;
          cnt_d        = 4'(EXEC_CYCLES - 1);
          state_d      = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rsp_result1_d = alu_result1;
          rsp_result2_d = alu_result2;
          rsp_flags_d   = alu_flags;
          rsp_valid_d   = 1'b1;
          state_d       = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      last_grant_q  <= 3'(NREQ - 1);
      cnt_q         <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_ctrl_q    <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_result1_q <= '0;
      rsp_result2_q <= '0;
      rsp_flags_q   <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      cnt_q         <= cnt_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_ctrl_q    <= alu_ctrl_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_result1_q <= rsp_result1_d;
      rsp_result2_q <= rsp_result2_d;
      rsp_flags_q   <= rsp_flags_d;
    end
  end

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_ctrl    = alu_ctrl_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_result1 = rsp_result1_q;
  assign rsp_result2 = rsp_result2_q;
  assign rsp_flags   = rsp_flags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: a 2-requester / 1-cycle instance (x_*) and a
// 4-requester / 3-cycle instance (y_*), each with a simple behavioural ALU
// (result1 = a+b, result2 = a-b, flags = a[3:0]^b[3:0]^{0,ctrl}).
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 2-requester, EXEC_CYCLES=1 instance
  logic [1:0]  x_req_valid, x_req_ready;
  logic [63:0] x_req_a, x_req_b;
  logic [5:0]  x_req_ctrl;
  logic [31:0] x_alu_a, x_alu_b, x_res1, x_res2, x_rsp_r1, x_rsp_r2;
  logic [2:0]  x_alu_ctrl, x_rsp_id;
  logic [3:0]  x_flags, x_rsp_flags;
  logic        x_rsp_valid, x_rsp_ready;

  // 4-requester, EXEC_CYCLES=3 instance
  logic [3:0]   y_req_valid, y_req_ready;
  logic [127:0] y_req_a, y_req_b;
  logic [11:0]  y_req_ctrl;
  logic [31:0]  y_alu_a, y_alu_b, y_res1, y_res2, y_rsp_r1, y_rsp_r2;
  logic [2:0]   y_alu_ctrl, y_rsp_id;
  logic [3:0]   y_flags, y_rsp_flags;
  logic         y_rsp_valid, y_rsp_ready;

  assign x_res1  = x_alu_a + x_alu_b;
  assign x_res2  = x_alu_a - x_alu_b;
  assign x_flags = x_alu_a[3:0] ^ x_alu_b[3:0] ^ {1'b0, x_alu_ctrl};
  assign y_res1  = y_alu_a + y_alu_b;
  assign y_res2  = y_alu_a - y_alu_b;
  assign y_flags = y_alu_a[3:0] ^ y_alu_b[3:0] ^ {1'b0, y_alu_ctrl};

  alu_arbiter #(.NREQ(2), .EXEC_CYCLES(1)) dut_x (
    .clk(clk), .reset(reset),
    .req_valid(x_req_valid), .req_ready(x_req_ready),
    .req_a(x_req_a), .req_b(x_req_b), .req_ctrl(x_req_ctrl),
    .alu_a(x_alu_a), .alu_b(x_alu_b), .alu_ctrl(x_alu_ctrl),
    .alu_result1(x_res1), .alu_result2(x_res2), .alu_flags(x_flags),
    .rsp_valid(x_rsp_valid), .rsp_ready(x_rsp_ready), .rsp_id(x_rsp_id),
    .rsp_result1(x_rsp_r1), .rsp_result2(x_rsp_r2), .rsp_flags(x_rsp_flags)
  );

  alu_arbiter #(.NREQ(4), .EXEC_CYCLES(3)) dut_y (
    .clk(clk), .reset(reset),
    .req_valid(y_req_valid), .req_ready(y_req_ready),
    .req_a(y_req_a), .req_b(y_req_b), .req_ctrl(y_req_ctrl),
    .alu_a(y_alu_a), .alu_b(y_alu_b), .alu_ctrl(y_alu_ctrl),
    .alu_result1(y_res1), .alu_result2(y_res2), .alu_flags(y_flags),
    .rsp_valid(y_rsp_valid), .rsp_ready(y_rsp_ready), .rsp_id(y_rsp_id),
    .rsp_result1(y_rsp_r1), .rsp_result2(y_rsp_r2), .rsp_flags(y_rsp_flags)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Observers for the withdrawn-request scenario on the 4-requester instance.
  bit          y_seen_ready2 = 1'b0;
  bit          y_seen_rsp2   = 1'b0;
  int unsigned y_handshakes  = 0;
  always @(negedge clk) begin
    if (y_req_ready[2]) y_seen_ready2 = 1'b1;
    if (y_rsp_valid && y_rsp_id == 3'd2) y_seen_rsp2 = 1'b1;
  end
  always @(posedge clk)
    if (!reset && y_rsp_valid && y_rsp_ready) y_handshakes++;

  typedef struct {
    int unsigned idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ctrl;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [3:0]  fl;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_x(input int unsigned idx, input logic [31:0] a,
                       input logic [31:0] b, input logic [2:0] c);
    if (idx == 0) begin
      x_req_a[31:0] = a; x_req_b[31:0] = b; x_req_ctrl[2:0] = c;
    end else begin
      x_req_a[63:32] = a; x_req_b[63:32] = b; x_req_ctrl[5:3] = c;
    end
  endtask

  task automatic wait_x_ready;
    int unsigned n = 0;
    #1;
    while (x_req_ready == '0 && n < 20) begin step; #1; n++; end
    if (x_req_ready == '0) begin
      checks++; errors++;
      $display("FAIL x_ready_timeout: actual no grant required grant within 20 cycles");
    end
  endtask

  task automatic wait_x_rsp;
    int unsigned n = 0;
    #1;
    while (!x_rsp_valid && n < 20) begin step; #1; n++; end
    if (!x_rsp_valid) begin
      checks++; errors++;
      $display("FAIL x_rsp_timeout: actual no response required response within 20 cycles");
    end
  endtask

  task automatic do_reset;
    reset = 1'b1;
    step;
    reset = 1'b0;
  endtask

  initial begin
    vecs[0] = '{0, 32'h0000_0005, 32'h0000_0003, 3'd0, 32'h0000_0008, 32'h0000_0002, 4'h6};
    vecs[1] = '{1, 32'hFFFF_FFFF, 32'h0000_0001, 3'd2, 32'h0000_0000, 32'hFFFF_FFFE, 4'hC};
    vecs[2] = '{0, 32'h8000_0000, 32'h8000_0000, 3'd1, 32'h0000_0000, 32'h0000_0000, 4'h1};
    vecs[3] = '{1, 32'h1234_5678, 32'h0F0F_0F0F, 3'd7, 32'h2143_6587, 32'h0325_4769, 4'h0};

    reset       = 1'b1;
    x_req_valid = 2'b11;
    x_req_a     = '0; x_req_b = '0; x_req_ctrl = '0;
    x_rsp_ready = 1'b1;
    y_req_valid = 4'b1111;
    y_req_a     = {32'h0000_4000, 32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
    y_req_b     = {32'd4, 32'd3, 32'd2, 32'd1};
    y_req_ctrl  = {3'd3, 3'd2, 3'd1, 3'd0};
    y_rsp_ready = 1'b1;

    // Reset state, with requests asserted to show req_ready is held low.
    @(negedge clk);
    step; #1;
    chk("reset_x_req_ready", 32'(x_req_ready), 32'd0);
    chk("reset_y_req_ready", 32'(y_req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(x_rsp_valid), 32'd0);
    chk("reset_alu_a", x_alu_a, 32'd0);
    chk("reset_rsp_id", 32'(x_rsp_id), 32'd0);
    chk("reset_rsp_result1", x_rsp_r1, 32'd0);
    chk("reset_rsp_flags", 32'(x_rsp_flags), 32'd0);
    x_req_valid = '0;
    y_req_valid = '0;
    reset       = 1'b0;
    step;

    // Table-driven single requests, EXEC_CYCLES=1.
    for (int v = 0; v < 4; v++) begin
      set_x(vecs[v].idx, vecs[v].a, vecs[v].b, vecs[v].ctrl);
      x_req_valid = 2'(1 << vecs[v].idx);
      #1;
      chk("vec_req_ready", 32'(x_req_ready), 32'(1) << vecs[v].idx);
      step;                        // accept edge
      x_req_valid = '0;
      #1;
      chk("vec_ready_dropped", 32'(x_req_ready), 32'd0);
      chk("vec_alu_a", x_alu_a, vecs[v].a);
      chk("vec_alu_b", x_alu_b, vecs[v].b);
      chk("vec_alu_ctrl", 32'(x_alu_ctrl), 32'(vecs[v].ctrl));
      chk("vec_no_early_rsp", 32'(x_rsp_valid), 32'd0);
      step;                        // capture edge
      #1;
      chk("vec_rsp_valid", 32'(x_rsp_valid), 32'd1);
      chk("vec_rsp_id", 32'(x_rsp_id), vecs[v].idx);
      chk("vec_rsp_result1", x_rsp_r1, vecs[v].r1);
      chk("vec_rsp_result2", x_rsp_r2, vecs[v].r2);
      chk("vec_rsp_flags", 32'(x_rsp_flags), 32'(vecs[v].fl));
      step;                        // handshake edge
      #1;
      chk("vec_rsp_cleared", 32'(x_rsp_valid), 32'd0);
    end

    // Simultaneous requests after reset: grants alternate 0,1,0,1.
    do_reset;
    set_x(0, 32'h0000_0100, 32'h0000_0001, 3'd0);
    set_x(1, 32'h0000_0200, 32'h0000_0002, 3'd1);
    x_req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_x_ready;
      chk("rr_grant", 32'(x_req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
      step;
      #1;
      chk("rr_alu_a", x_alu_a, (k % 2 == 0) ? 32'h100 : 32'h200);
      chk("rr_alu_b", x_alu_b, (k % 2 == 0) ? 32'h1 : 32'h2);
      wait_x_rsp;
      chk("rr_rsp_id", 32'(x_rsp_id), (k % 2 == 0) ? 32'd0 : 32'd1);
      step;
    end

    // Backpressure: requester 0 is next after the 0,1,0,1 sequence.
    x_rsp_ready = 1'b0;
    wait_x_ready;
    chk("bp_grant", 32'(x_req_ready), 32'd1);
    step;
    wait_x_rsp;
    for (int k = 0; k < 5; k++) begin
      chk("bp_rsp_valid", 32'(x_rsp_valid), 32'd1);
      chk("bp_rsp_result1", x_rsp_r1, 32'h101);
      chk("bp_rsp_id", 32'(x_rsp_id), 32'd0);
      chk("bp_req_ready", 32'(x_req_ready), 32'd0);
      step; #1;
    end
    x_rsp_ready = 1'b1;
    #1;
    chk("bp_no_accept_on_handshake", 32'(x_req_ready), 32'd0);
    step; #1;
    chk("bp_rsp_released", 32'(x_rsp_valid), 32'd0);
    chk("bp_idle_regrant", 32'(x_req_ready), 32'd2);
    x_req_valid = '0;
    step;

    // Reset mid-EXEC: operation dropped, arbitration restarts at requester 0.
    x_req_valid = 2'b01;
    wait_x_ready;
    step;
    x_req_valid = '0;
    #1;
    chk("rst_mid_alu_a_before", x_alu_a, 32'h100);
    reset = 1'b1;
    step;
    reset = 1'b0;
    #1;
    chk("rst_mid_alu_a", x_alu_a, 32'd0);
    begin
      bit rose = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (x_rsp_valid) rose = 1'b1;
        step; #1;
      end
      chk("rst_mid_no_rsp", 32'(rose), 32'd0);
    end
    x_req_valid = 2'b11;
    #1;
    chk("rst_mid_grant0", 32'(x_req_ready), 32'd1);
    x_req_valid = '0;
    step;

    // Multi-cycle execute on the 4-requester, EXEC_CYCLES=3 instance.
    y_req_valid = 4'b1000;
    #1;
    chk("mc_grant3", 32'(y_req_ready), 32'h8);
    step;                          // accept edge E0
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("mc_alu_a_hold", y_alu_a, 32'h4000);
      chk("mc_alu_b_hold", y_alu_b, 32'd4);
      chk("mc_alu_ctrl_hold", 32'(y_alu_ctrl), 32'd3);
      chk("mc_no_early_rsp", 32'(y_rsp_valid), 32'd0);
      step;
    end
    #1;                            // after E3
    chk("mc_rsp_valid", 32'(y_rsp_valid), 32'd1);
    chk("mc_rsp_id", 32'(y_rsp_id), 32'd3);
    chk("mc_rsp_result1", y_rsp_r1, 32'h4004);
    chk("mc_rsp_result2", y_rsp_r2, 32'h3FFC);
    chk("mc_rsp_flags", 32'(y_rsp_flags), 32'h7);
    chk("mc_not_ready_in_resp", 32'(y_req_ready), 32'd0);
    step; #1;                      // after E4: IDLE again, next accept at E5
    chk("mc_issue_interval_ready", 32'(y_req_ready), 32'h8);

    // Withdrawn request: requester 2 pulses only while the ALU is busy.
    y_req_valid = 4'b0001;
    #1;
    chk("wd_grant0", 32'(y_req_ready), 32'h1);
    step;                          // accept requester 0
    y_req_valid = 4'b0101;
    step; step; step;              // EXEC cycles, now in RESP
    y_req_valid = 4'b0001;
    step; #1;                      // back in IDLE
    chk("wd_next_grant0", 32'(y_req_ready), 32'h1);
    y_req_valid = '0;
    step; step;
    chk("wd_never_ready2", 32'(y_seen_ready2), 32'd0);
    chk("wd_no_rsp2", 32'(y_seen_rsp2), 32'd0);
    chk("wd_handshake_count", y_handshakes, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual still running required finish");
    $fatal(1);
  end

endmodule
